imem_loader: RTL and testbench

//  Writer side of the instruction memory. Receives a program as a byte stream over a

---
 rtl/imem_loader.sv | 191 +++++++++++++++++++
 tb/tb_imem_loader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Instruction-memory loader: packs a little-endian byte stream into N-bit
// words, writes them to consecutive RAM addresses from 0, and keeps the CPU
// in reset until the program has been fully written.

// Run-time invariants of the loader outputs.
module imem_loader_chk (
    input logic clk,
    input logic reset,
    input logic in_ready,
    input logic we,
    input logic busy,
    input logic done,
    input logic cpu_hold
);

    // A write strobe never lasts longer than one cycle.
    a_we_pulse: assert property (@(posedge clk) disable iff (reset) we |=> !we);

    // No byte is accepted while a word is being written.
    a_we_not_ready: assert property (@(posedge clk) disable iff (reset) !(we && in_ready));

    // A finished load is never reported as still running.
    a_done_busy: assert property (@(posedge clk) disable iff (reset) !(done && busy));

    // The CPU is released once the load has finished.
    a_done_release: assert property (@(posedge clk) disable iff (reset) done |-> !cpu_hold);

endmodule

module imem_loader #(
    parameter int N  = 32,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW:0]   nwords,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [N-1:0]  wdata,
    output logic          busy,
    output logic          done,
    output logic          cpu_hold
);

    localparam int BYTES = N / 8;
    localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
    // Full RAM depth expressed in the word-counter width.
    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_q;
    logic [BCW-1:0]  byte_cnt_q;
    logic [AW:0]     word_cnt_q;
    logic [AW:0]     nwords_q;
    logic            we_q;
    logic [AW-1:0]   waddr_q;
    logic [N-1:0]    wdata_q;
    logic            busy_q;
    logic            done_q;
    logic            hold_q;

    logic [AW:0]     nwords_clamped_d;
    logic [AW:0]     word_cnt_inc_d;
    logic            last_byte_d;

    // Requests beyond the RAM depth are limited to the full depth.
    function automatic logic [AW:0] clamp_words(input logic [AW:0] n);
        if (n > DEPTH) begin
            return DEPTH;
        end else begin
            return n;
        end
    endfunction

    // Helper values for the state register: clamped request, next word count, last byte of word.
    always_comb begin
        nwords_clamped_d = clamp_words(nwords);
        word_cnt_inc_d   = word_cnt_q + (AW+1)'(1);
        last_byte_d      = (byte_cnt_q == BCW'(BYTES - 1));
    end

    // Loader FSM with all outputs held in registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            nwords_q   <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hold_q     <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    we_q <= 1'b0;
                    if (start) begin
                        nwords_q   <= nwords_clamped_d;
                        word_cnt_q <= '0;
                        byte_cnt_q <= '0;
                        waddr_q    <= '0;
                        if (nwords_clamped_d == '0) begin
                            // Empty program: finish at once, nothing is written.
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            hold_q  <= 1'b0;
                        end else begin
                            state_q <= S_LOAD;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                            hold_q  <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    we_q <= 1'b0;
                    if (in_valid) begin
                        // Little-endian packing: byte k lands in bits [8k+7:8k].
                        for (int i = 0; i < BYTES; i++) begin
                            if (byte_cnt_q == BCW'(i)) begin
                                wdata_q[8*i +: 8] <= in_data;
                            end
                        end
                        byte_cnt_q <= byte_cnt_q + BCW'(1);
                        if (last_byte_d) begin
                            state_q <= S_WRITE;
                            we_q    <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    we_q       <= 1'b0;
                    // The final increment may wrap to 0; the word counter is one bit wider.
                    waddr_q    <= waddr_q + AW'(1);
                    byte_cnt_q <= '0;
                    word_cnt_q <= word_cnt_inc_d;
                    if (word_cnt_inc_d == nwords_q) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        hold_q  <= 1'b0;
                    end else begin
                        state_q <= S_LOAD;
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to a quiet, CPU-held state.
                    state_q    <= S_IDLE;
                    byte_cnt_q <= '0;
                    we_q       <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                    hold_q     <= 1'b1;
                end
            endcase
        end
    end

    // in_ready is a decode of the state register only.
    assign in_ready = (state_q == S_LOAD);
    assign we       = we_q;
    assign waddr    = waddr_q;
    assign wdata    = wdata_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign cpu_hold = hold_q;

    imem_loader_chk u_chk (
        .clk      (clk),
        .reset    (reset),
        .in_ready (in_ready),
        .we       (we),
        .busy     (busy),
        .done     (done),
        .cpu_hold (cpu_hold)
    );

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a word-level model (expected write list built by
// packing the byte stream) checked against every write strobe, plus
// hand-computed literal expectations for the directed scenarios.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [6:0]  nwords;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        we;
    logic [5:0]  waddr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        cpu_hold;

    imem_loader #(.N(32), .AW(6)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .nwords   (nwords),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .cpu_hold (cpu_hold)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [37:0] exp_q[$];   // expected writes {addr, data}
    logic [37:0] wlog[$];    // writes observed on the RAM port
    logic [7:0]  stim[$];    // byte stream of the current test

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pack_word(input logic [7:0] b0, input logic [7:0] b1,
                                              input logic [7:0] b2, input logic [7:0] b3);
        return {b3, b2, b1, b0};
    endfunction

    // Per-cycle compare against the model and the output rules.
    initial begin
        bit          prev_we   = 1'b0;
        bit          seen_done = 1'b0;
        logic [37:0] e;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_we   = 1'b0;
                seen_done = 1'b0;
            end else begin
                if (we) begin
                    wlog.push_back({waddr, wdata});
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_write: got %0h expected no write", {waddr, wdata});
                    end else begin
                        e = exp_q.pop_front();
                        chk("write", {26'd0, waddr, wdata}, {26'd0, e});
                    end
                    chk("we_one_cycle", {63'd0, prev_we}, 64'd0);
                end
                chk("ready_with_we", {63'd0, in_ready & we}, 64'd0);
                chk("done_with_busy", {63'd0, done & busy}, 64'd0);
                chk("cpu_hold", {63'd0, cpu_hold}, {63'd0, (seen_done || done) ? busy : 1'b1});
                if (done) seen_done = 1'b1;
                prev_we = we;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd0);
        chk({tag, "_we"},       {63'd0, we},       64'd0);
        chk({tag, "_waddr"},    {58'd0, waddr},    64'd0);
        chk({tag, "_wdata"},    {32'd0, wdata},    64'd0);
        chk({tag, "_busy"},     {63'd0, busy},     64'd0);
        chk({tag, "_done"},     {63'd0, done},     64'd0);
        chk({tag, "_cpu_hold"}, {63'd0, cpu_hold}, 64'd1);
    endtask

    task automatic do_start(input int n);
        nwords = n[6:0];
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Offer one byte and hold it until the loader takes it.
    task automatic send_byte(input logic [7:0] b, input bit gap);
        int budget = 0;
        if (gap) begin
            in_valid = 1'b0;
            in_data  = 8'h5a;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        chk("ready_timeout", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int budget = 0;
        while (!done && budget < 40) begin
            @(negedge clk);
            budget++;
        end
        chk("done_timeout", {63'd0, done}, 64'd1);
    endtask

    task automatic push_model(input int eff);
        for (int w = 0; w < eff; w++) begin
            exp_q.push_back({w[5:0], pack_word(stim[4*w], stim[4*w+1], stim[4*w+2], stim[4*w+3])});
        end
    endtask

    // Complete load of n words taken from stim.
    task automatic run_load(input int n, input bit gap);
        int eff;
        eff = (n > 64) ? 64 : n;
        push_model(eff);
        wlog.delete();
        do_start(n);
        chk("start_busy",  {63'd0, busy},     64'd1);
        chk("start_done",  {63'd0, done},     64'd0);
        chk("start_hold",  {63'd0, cpu_hold}, 64'd1);
        chk("start_waddr", {58'd0, waddr},    64'd0);
        for (int i = 0; i < eff * 4; i++) begin
            send_byte(stim[i], gap);
        end
        wait_done();
        chk("drained",     64'(exp_q.size()), 64'd0);
        chk("nwrites",     64'(wlog.size()),  64'(eff));
        chk("end_busy",    {63'd0, busy},     64'd0);
        chk("end_hold",    {63'd0, cpu_hold}, 64'd0);
        chk("end_waddr",   {58'd0, waddr},    64'(eff % 64));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        nwords   = 7'd0;
        in_data  = 8'd0;
        in_valid = 1'b0;
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Pin the model against hand-packed words.
        chk("model_pin0", {32'd0, pack_word(8'hc5, 8'h03, 8'h1e, 8'h8b)}, {32'd0, 32'h8b1e03c5});
        chk("model_pin1", {32'd0, pack_word(8'hfc, 8'hfd, 8'hfe, 8'hff)}, {32'd0, 32'hfffefdfc});

        // nwords = 0: done next cycle, no writes.
        wlog.delete();
        do_start(0);
        chk("zero_done",  {63'd0, done},     64'd1);
        chk("zero_busy",  {63'd0, busy},     64'd0);
        chk("zero_hold",  {63'd0, cpu_hold}, 64'd0);
        chk("zero_waddr", {58'd0, waddr},    64'd0);
        repeat (3) @(negedge clk);
        chk("zero_nwrites", 64'(wlog.size()), 64'd0);

        // Two-word program, back-to-back then with gaps in in_valid.
        stim = '{8'hc5, 8'h03, 8'h1e, 8'h8b, 8'ha5, 8'h00, 8'h04, 8'h8b};
        for (int g = 0; g < 2; g++) begin
            run_load(2, g[0]);
            chk("t12_w0", {26'd0, wlog[0]}, {26'd0, 6'd0, 32'h8b1e03c5});
            chk("t12_w1", {26'd0, wlog[1]}, {26'd0, 6'd1, 32'h8b0400a5});
        end

        // start during LOAD is ignored; start in DONE reloads from 0.
        stim = '{8'h11, 8'h22, 8'h33, 8'h44};
        push_model(1);
        wlog.delete();
        do_start(1);
        send_byte(stim[0], 1'b0);
        send_byte(stim[1], 1'b0);
        do_start(3);
        chk("ign_busy", {63'd0, busy}, 64'd1);
        chk("ign_done", {63'd0, done}, 64'd0);
        send_byte(stim[2], 1'b0);
        send_byte(stim[3], 1'b0);
        wait_done();
        chk("ign_waddr",   {58'd0, waddr},   64'd1);
        chk("ign_nwrites", 64'(wlog.size()), 64'd1);
        chk("ign_w0",      {26'd0, wlog[0]}, {26'd0, 6'd0, 32'h44332211});
        stim = '{8'hde, 8'had, 8'hbe, 8'hef};
        run_load(1, 1'b0);
        chk("reload_w0", {26'd0, wlog[0]}, {26'd0, 6'd0, 32'hefbeadde});

        // Full RAM, then an oversized request clamped to full depth.
        stim.delete();
        for (int i = 0; i < 256; i++) stim.push_back(i[7:0]);
        run_load(64, 1'b0);
        chk("full_w63", {26'd0, wlog[63]}, {26'd0, 6'd63, 32'hfffefdfc});
        chk("full_w1",  {26'd0, wlog[1]},  {26'd0, 6'd1,  32'h07060504});
        run_load(100, 1'b1);
        chk("clamp_w63", {26'd0, wlog[63]}, {26'd0, 6'd63, 32'hfffefdfc});

        // Reset after two bytes of the second word: partial word dropped.
        stim.delete();
        for (int i = 0; i < 8; i++) stim.push_back(8'h30 + i[7:0]);
        push_model(2);
        wlog.delete();
        do_start(2);
        for (int i = 0; i < 6; i++) send_byte(stim[i], 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("midrst");
        exp_q.delete();
        chk("midrst_nwrites", 64'(wlog.size()), 64'd1);
        chk("midrst_w0", {26'd0, wlog[0]}, {26'd0, 6'd0, 32'h33323130});
        @(negedge clk);
        @(negedge clk);
        chk("midrst_held", {63'd0, we}, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        stim = '{8'h1f, 8'h00, 8'h00, 8'hb4};
        run_load(1, 1'b0);
        chk("post_rst_w0", {26'd0, wlog[0]}, {26'd0, 6'd0, 32'hb400001f});

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
